// File: rtl/bcd_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : bcd_scan_ctrl_if
// Purpose  : Value-source and decoder/driver signals of the BCD scan controller.
// Revision : 1.0
// ============================================================================
interface bcd_scan_ctrl_if #(
  parameter int NDIG = 4
);
  logic              run;
  logic              load;
  logic [4*NDIG-1:0] bcd_in;
  logic              dec_e;
  logic              dec_a;
  logic              dec_b;
  logic              dec_c;
  logic              dec_d;
  logic [NDIG-1:0]   dig_sel;
  logic              frame_done;
  logic              busy;
  logic              err;

  modport master (
    output run, load, bcd_in,
    input  dec_e, dec_a, dec_b, dec_c, dec_d, dig_sel, frame_done, busy, err
  );

  modport slave (
    input  run, load, bcd_in,
    output dec_e, dec_a, dec_b, dec_c, dec_d, dig_sel, frame_done, busy, err
  );
endinterface
`default_nettype wire

// File: rtl/bcd_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bcd_scan_ctrl
// Purpose  : Scans NDIG double-buffered BCD digits onto one shared decoder.
// Revision : 1.0
// ============================================================================
module bcd_scan_ctrl #(
  parameter int NDIG      = 4,
  parameter int PRESCALE  = 1000,
  parameter int BLANK_CYC = 2,
  parameter bit E_ACTIVE  = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  bcd_scan_ctrl_if.slave  bus
);

  localparam int C_PRE_W   = $clog2(PRESCALE);
  localparam int C_BLK_W   = $clog2(BLANK_CYC);
  localparam int C_MAX_W   = (C_PRE_W > C_BLK_W) ? C_PRE_W : C_BLK_W;
  localparam int C_CNT_W   = (C_MAX_W < 1) ? 1 : C_MAX_W;
  localparam int C_IDX_W   = $clog2(NDIG);
  localparam int C_VAL_W   = 4 * NDIG;

  localparam logic [C_CNT_W-1:0] C_PRE_LAST = C_CNT_W'(PRESCALE - 1);
  localparam logic [C_CNT_W-1:0] C_BLK_LAST = C_CNT_W'(BLANK_CYC - 1);
  localparam logic [C_IDX_W-1:0] C_IDX_LAST = C_IDX_W'(NDIG - 1);
  localparam logic               C_E_ON     = E_ACTIVE;
  localparam logic               C_E_OFF    = ~E_ACTIVE;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [C_CNT_W-1:0]   cnt_q, cnt_d;
  logic [C_IDX_W-1:0]   idx_q, idx_d;
  logic [C_VAL_W-1:0]   active_q, active_d;
  logic [C_VAL_W-1:0]   pending_q, pending_d;
  logic                 pend_v_q, pend_v_d;
  logic                 dec_e_q, dec_e_d;
  logic [3:0]           abcd_q, abcd_d;
  logic [NDIG-1:0]      dig_sel_q, dig_sel_d;
  logic                 frame_done_q, frame_done_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;

  logic                 frame_end;
  logic [3:0]           digit_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      active_q     <= '0;
      pending_q    <= '0;
      pend_v_q     <= 1'b0;
      dec_e_q      <= C_E_OFF;
      abcd_q       <= 4'd0;
      dig_sel_q    <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      pend_v_q     <= pend_v_d;
      dec_e_q      <= dec_e_d;
      abcd_q       <= abcd_d;
      dig_sel_q    <= dig_sel_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    active_d     = active_q;
    pending_d    = pending_q;
    pend_v_d     = pend_v_q;
    err_d        = err_q;
    frame_end    = 1'b0;
    dec_e_d      = C_E_OFF;
    abcd_d       = 4'd0;
    dig_sel_d    = '0;
    frame_done_d = 1'b0;
    busy_d       = 1'b0;
    digit_d      = 4'd0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (bus.run) begin
          state_d = ST_BLANK;
          if (pend_v_q) begin
            active_d = pending_q;
            pend_v_d = 1'b0;
          end
        end
      end
      ST_BLANK: begin
        if (cnt_q == C_BLK_LAST) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SHOW: begin
        if (cnt_q == C_PRE_LAST) begin
          cnt_d = '0;
          if (idx_q == C_IDX_LAST) begin
            frame_end = 1'b1;
            idx_d     = '0;
            if (pend_v_q) begin
              active_d = pending_q;
              pend_v_d = 1'b0;
            end
            state_d = bus.run ? ST_BLANK : ST_IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_BLANK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase

    // A load on the frame boundary goes straight to the next frame's value.
    if (bus.load) begin
      err_d = 1'b0;
      if (frame_end) begin
        active_d = bus.bcd_in;
        pend_v_d = 1'b0;
      end else begin
        pending_d = bus.bcd_in;
        pend_v_d  = 1'b1;
        if (state_q == ST_IDLE) begin
          active_d = bus.bcd_in;
        end
      end
    end

    // Outputs are registered, so they are derived from the next-cycle state.
    digit_d = active_d[{idx_d, 2'b00} +: 4];
    busy_d  = (state_d != ST_IDLE);
    case (state_d)
      ST_BLANK: begin
        abcd_d = digit_d;
      end
      ST_SHOW: begin
        abcd_d = digit_d;
        if (digit_d <= 4'd9) begin
          dec_e_d   = C_E_ON;
          dig_sel_d = {{(NDIG-1){1'b0}}, 1'b1} << idx_d;
        end else if (state_q != ST_SHOW) begin
          err_d = 1'b1;
        end
        frame_done_d = (idx_d == C_IDX_LAST) && (cnt_d == C_PRE_LAST);
      end
      default: begin
        abcd_d = 4'd0;
      end
    endcase
  end

  assign bus.dec_e      = dec_e_q;
  assign bus.dec_a      = abcd_q[3];
  assign bus.dec_b      = abcd_q[2];
  assign bus.dec_c      = abcd_q[1];
  assign bus.dec_d      = abcd_q[0];
  assign bus.dig_sel    = dig_sel_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = busy_q;
  assign bus.err        = err_q;

endmodule
`default_nettype wire
